// File: rtl/mc_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mc_control
// Purpose  : Multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP) with
//            ready-handshaked data memory, access timeout and illegal-op trap.
// Revision : 1.0  initial release
// ============================================================================
module mc_control #(
    parameter int MEM_TIMEOUT   = 16,
    parameter int CNT_W         = 5,
    parameter int ENABLE_BYTE   = 1,
    parameter int ENABLE_BLTZAL = 1
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    input  logic       branch_i,
    input  logic       mem_ready_i,
    output logic       PCWr_o,
    output logic       IRWr_o,
    output logic [1:0] NPCop_o,
    output logic [1:0] WRsel_o,
    output logic [1:0] WDsel_o,
    output logic       RFWr_o,
    output logic       EXTop_o,
    output logic       Bsel_o,
    output logic [2:0] ALUop_o,
    output logic [1:0] DMWr_o,
    output logic [1:0] DMsel_o,
    output logic       retire_o,
    output logic       trap_o,
    output logic [1:0] trap_cause_o
);

    localparam logic [5:0] c_op_special = 6'b000000;
    localparam logic [5:0] c_op_regimm  = 6'b000001;
    localparam logic [5:0] c_op_j       = 6'b000010;
    localparam logic [5:0] c_op_jal     = 6'b000011;
    localparam logic [5:0] c_op_beq     = 6'b000100;
    localparam logic [5:0] c_op_ori     = 6'b001101;
    localparam logic [5:0] c_op_lui     = 6'b001111;
    localparam logic [5:0] c_op_lb      = 6'b100000;
    localparam logic [5:0] c_op_lh      = 6'b100001;
    localparam logic [5:0] c_op_lw      = 6'b100011;
    localparam logic [5:0] c_op_sb      = 6'b101000;
    localparam logic [5:0] c_op_sh      = 6'b101001;
    localparam logic [5:0] c_op_sw      = 6'b101011;
    localparam logic [5:0] c_fn_add     = 6'b100000;
    localparam logic [5:0] c_fn_sub     = 6'b100010;
    localparam logic [5:0] c_fn_jr      = 6'b001000;

    localparam logic [1:0] c_cause_none    = 2'b00;
    localparam logic [1:0] c_cause_illegal = 2'b01;
    localparam logic [1:0] c_cause_timeout = 2'b10;

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cause_q, cause_d;

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    logic w_special, w_add, w_sub, w_jr, w_ori, w_lui, w_j, w_jal, w_beq;
    logic w_lw, w_sw, w_lb, w_lh, w_sb, w_sh, w_bltzal;
    logic w_load, w_store, w_legal;

    assign w_special = (opcode_i == c_op_special);
    assign w_add     = w_special && (funct_i == c_fn_add);
    assign w_sub     = w_special && (funct_i == c_fn_sub);
    assign w_jr      = w_special && (funct_i == c_fn_jr);
    assign w_ori     = (opcode_i == c_op_ori);
    assign w_lui     = (opcode_i == c_op_lui);
    assign w_j       = (opcode_i == c_op_j);
    assign w_jal     = (opcode_i == c_op_jal);
    assign w_beq     = (opcode_i == c_op_beq);
    assign w_lw      = (opcode_i == c_op_lw);
    assign w_sw      = (opcode_i == c_op_sw);
    assign w_lb      = (ENABLE_BYTE != 0) && (opcode_i == c_op_lb);
    assign w_lh      = (ENABLE_BYTE != 0) && (opcode_i == c_op_lh);
    assign w_sb      = (ENABLE_BYTE != 0) && (opcode_i == c_op_sb);
    assign w_sh      = (ENABLE_BYTE != 0) && (opcode_i == c_op_sh);
    assign w_bltzal  = (ENABLE_BLTZAL != 0) && (opcode_i == c_op_regimm);

    assign w_load  = w_lw || w_lb || w_lh;
    assign w_store = w_sw || w_sb || w_sh;
    assign w_legal = w_add || w_sub || w_jr || w_ori || w_lui || w_j || w_jal ||
                     w_beq || w_bltzal || w_load || w_store;

    // Datapath steering that is harmless outside EXEC/MEM is driven from decode
    logic       w_extop, w_bsel;
    logic [2:0] w_aluop;
    logic [1:0] w_dmsel;

    assign w_extop = w_beq || w_load || w_store;
    assign w_bsel  = w_ori || w_lui || w_load || w_store;
    assign w_aluop = w_sub || w_beq ? 3'b001 :
                     w_ori          ? 3'b010 :
                     w_lui          ? 3'b011 : 3'b000;
    assign w_dmsel = (w_lh || w_sh) ? 2'b01 :
                     (w_lb || w_sb) ? 2'b10 : 2'b00;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            cause_q <= c_cause_none;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and raw controls
    // ------------------------------------------------------------------
    logic       w_pcwr, w_irwr, w_rfwr;
    logic [1:0] w_npcop, w_wrsel, w_wdsel, w_dmwr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cause_d = cause_q;
        w_pcwr  = 1'b0;
        w_irwr  = 1'b0;
        w_rfwr  = 1'b0;
        w_npcop = 2'b00;
        w_wrsel = 2'b00;
        w_wdsel = 2'b00;
        w_dmwr  = 2'b00;
        unique case (state_q)
            S_FETCH: begin
                w_irwr  = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (w_j || w_jal) begin
                    w_pcwr  = 1'b1;
                    w_npcop = 2'b10;
                    if (w_jal) begin
                        w_rfwr  = 1'b1;
                        w_wrsel = 2'b11;
                        w_wdsel = 2'b10;
                    end
                    state_d = S_FETCH;
                end else if (w_jr) begin
                    w_pcwr  = 1'b1;
                    w_npcop = 2'b11;
                    state_d = S_FETCH;
                end else if (!w_legal) begin
                    cause_d = c_cause_illegal;
                    state_d = S_TRAP;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (w_beq || w_bltzal) begin
                    // NPC selects target or PC+4 itself from the branch flag
                    w_pcwr  = 1'b1;
                    w_npcop = 2'b01;
                    if (w_bltzal) begin
                        w_rfwr  = branch_i;
                        w_wrsel = 2'b11;
                        w_wdsel = 2'b10;
                    end
                    state_d = S_FETCH;
                end else if (w_load || w_store) begin
                    cnt_d   = '0;
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                w_dmwr = w_store ? 2'b10 : 2'b01;
                if (mem_ready_i) begin
                    if (w_store) begin
                        w_pcwr  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (cnt_q == c_cnt_last) begin
                    cause_d = c_cause_timeout;
                    state_d = S_TRAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                w_rfwr = 1'b1;
                w_pcwr = 1'b1;
                if (w_load) begin
                    w_wdsel = 2'b01;
                end else if (w_add || w_sub) begin
                    w_wrsel = 2'b01;
                end
                state_d = S_FETCH;
            end
            S_TRAP: begin
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: enables are masked while reset is asserted
    // ------------------------------------------------------------------
    assign PCWr_o       = w_pcwr && !reset_i;
    assign retire_o     = PCWr_o;
    assign IRWr_o       = w_irwr && !reset_i;
    assign RFWr_o       = w_rfwr && !reset_i;
    assign DMWr_o       = reset_i ? 2'b00 : w_dmwr;
    assign NPCop_o      = w_npcop;
    assign WRsel_o      = w_wrsel;
    assign WDsel_o      = w_wdsel;
    assign EXTop_o      = w_extop;
    assign Bsel_o       = w_bsel;
    assign ALUop_o      = w_aluop;
    assign DMsel_o      = w_dmsel;
    assign trap_o       = (state_q == S_TRAP) && !reset_i;
    assign trap_cause_o = trap_o ? cause_q : c_cause_none;

endmodule
`default_nettype wire

// File: tb/tb_mc_control.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mc_control
// Purpose  : Table-driven scoreboard bench for mc_control plus corner sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_mc_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       branch, mem_ready;

    logic       PCWr, IRWr, RFWr, EXTop, Bsel, retire, trap;
    logic [1:0] NPCop, WRsel, WDsel, DMWr, DMsel, trap_cause;
    logic [2:0] ALUop;

    logic       d2_PCWr, d2_IRWr, d2_RFWr, d2_EXTop, d2_Bsel, d2_retire, d2_trap;
    logic [1:0] d2_NPCop, d2_WRsel, d2_WDsel, d2_DMWr, d2_DMsel, d2_cause;
    logic [2:0] d2_ALUop;

    always #5 clk = ~clk;

    mc_control #(.MEM_TIMEOUT(16), .CNT_W(5), .ENABLE_BYTE(1), .ENABLE_BLTZAL(1)) dut (
        .clk_i(clk), .reset_i(reset), .opcode_i(opcode), .funct_i(funct),
        .branch_i(branch), .mem_ready_i(mem_ready),
        .PCWr_o(PCWr), .IRWr_o(IRWr), .NPCop_o(NPCop), .WRsel_o(WRsel), .WDsel_o(WDsel),
        .RFWr_o(RFWr), .EXTop_o(EXTop), .Bsel_o(Bsel), .ALUop_o(ALUop), .DMWr_o(DMWr),
        .DMsel_o(DMsel), .retire_o(retire), .trap_o(trap), .trap_cause_o(trap_cause)
    );

    // Reduced-ISA variant: byte/half ops and bltzal must trap as illegal
    mc_control #(.MEM_TIMEOUT(16), .CNT_W(5), .ENABLE_BYTE(0), .ENABLE_BLTZAL(0)) dut2 (
        .clk_i(clk), .reset_i(reset), .opcode_i(opcode), .funct_i(funct),
        .branch_i(branch), .mem_ready_i(mem_ready),
        .PCWr_o(d2_PCWr), .IRWr_o(d2_IRWr), .NPCop_o(d2_NPCop), .WRsel_o(d2_WRsel),
        .WDsel_o(d2_WDsel), .RFWr_o(d2_RFWr), .EXTop_o(d2_EXTop), .Bsel_o(d2_Bsel),
        .ALUop_o(d2_ALUop), .DMWr_o(d2_DMWr), .DMsel_o(d2_DMsel), .retire_o(d2_retire),
        .trap_o(d2_trap), .trap_cause_o(d2_cause)
    );

    typedef struct {
        logic [5:0] op;
        logic [5:0] fn;
        logic       br;
        int         w;       // MEM cycles without mem_ready before it is given
        int         cyc;     // cycles to retire, or cycle on which trap appears
        logic [1:0] cause;
        logic       rf;
        logic [1:0] wrsel;
        logic [1:0] wdsel;
        int         dm;      // cycles with DMWr != 0
        logic [1:0] dmwr;
        logic [1:0] dmsel;
        logic [1:0] npc;
        logic       chk_alu;
        logic [2:0] alu;
        logic       bsel;
        logic       ext;
    } vec_t;

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn, input logic br,
                                input int w, input int cyc, input logic [1:0] cause,
                                input logic rf, input logic [1:0] wrsel, input logic [1:0] wdsel,
                                input int dm, input logic [1:0] dmwr, input logic [1:0] dmsel,
                                input logic [1:0] npc, input logic chk_alu, input logic [2:0] alu,
                                input logic bsel, input logic ext);
        vec_t v;
        v.op = op; v.fn = fn; v.br = br; v.w = w; v.cyc = cyc; v.cause = cause;
        v.rf = rf; v.wrsel = wrsel; v.wdsel = wdsel; v.dm = dm; v.dmwr = dmwr;
        v.dmsel = dmsel; v.npc = npc; v.chk_alu = chk_alu; v.alu = alu;
        v.bsel = bsel; v.ext = ext;
        return v;
    endfunction

    int   n_cmp = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    bit   need_reset = 1'b1;
    vec_t sb_q[$];
    vec_t vt[22];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: accumulates per-instruction observations, pops on retire/trap
    // ------------------------------------------------------------------
    int         cyc, dm_cnt, d2_trap_cyc;
    bit         rf_seen, prev_trap, d2_prev;
    logic [1:0] a_wrsel, a_wdsel, a_dmwr, a_dmsel, a_npc;
    logic [2:0] a_alu;
    logic       a_bsel, a_ext;
    vec_t       e;

    task automatic clear_acc();
        cyc = 0; dm_cnt = 0; rf_seen = 0;
        a_wrsel = 0; a_wdsel = 0; a_dmwr = 0; a_dmsel = 0; a_npc = 0;
        a_alu = 0; a_bsel = 0; a_ext = 0;
    endtask

    always @(negedge clk) begin
        if (reset) begin
            clear_acc();
            prev_trap = 0; d2_prev = 0; d2_trap_cyc = 0;
        end else begin
            cyc++;
            if (RFWr) begin rf_seen = 1; a_wrsel = WRsel; a_wdsel = WDsel; end
            if (DMWr != 2'b00) begin dm_cnt++; a_dmwr = DMWr; a_dmsel = DMsel; end
            if (cyc == 3) begin a_alu = ALUop; a_bsel = Bsel; a_ext = EXTop; end
            if (PCWr) a_npc = NPCop;
            chk("retire_eq_pcwr", int'(retire), int'(PCWr));
            if (d2_trap && !d2_prev) d2_trap_cyc = cyc;
            d2_prev = d2_trap;
            if (PCWr || (trap && !prev_trap)) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_completion", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("cycles", cyc, e.cyc);
                    chk("trap_cause", int'(trap_cause), int'(e.cause));
                    chk("rfwr", int'(rf_seen), int'(e.rf));
                    if (e.rf) begin
                        chk("wrsel", int'(a_wrsel), int'(e.wrsel));
                        chk("wdsel", int'(a_wdsel), int'(e.wdsel));
                    end
                    chk("dm_cycles", dm_cnt, e.dm);
                    if (e.dm > 0) begin
                        chk("dmwr", int'(a_dmwr), int'(e.dmwr));
                        chk("dmsel", int'(a_dmsel), int'(e.dmsel));
                    end
                    if (e.cause == 2'b00) begin
                        chk("npcop", int'(a_npc), int'(e.npc));
                        if (e.cyc >= 3) begin
                            chk("bsel", int'(a_bsel), int'(e.bsel));
                            chk("extop", int'(a_ext), int'(e.ext));
                            if (e.chk_alu) chk("aluop", int'(a_alu), int'(e.alu));
                        end
                    end
                end
                clear_acc();
                done_cnt++;
            end
            prev_trap = trap;
        end
    end

    // ------------------------------------------------------------------
    // Driver
    // ------------------------------------------------------------------
    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; mem_ready = 1'b0;
        #1 chk("rst_enables_now", int'({PCWr, IRWr, RFWr, retire, DMWr}), 0);
        repeat (3) begin
            @(negedge clk); #1;
            chk("rst_enables", int'({PCWr, IRWr, RFWr, retire, DMWr}), 0);
            chk("rst_trap", int'({trap, trap_cause}), 0);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #1;
        chk("fetch_irwr", int'({IRWr, PCWr, trap}), 4);
    endtask

    task automatic run_vec(input vec_t v);
        int start, memcnt;
        bit ok;
        sb_q.push_back(v);
        opcode = v.op; funct = v.fn; branch = v.br; mem_ready = 1'b0;
        if (need_reset) begin
            do_reset();
            need_reset = 1'b0;
        end
        start = done_cnt; memcnt = 0; ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (done_cnt != start) begin ok = 1'b1; break; end
            if (DMWr != 2'b00) begin
                memcnt++;
                mem_ready = (memcnt == v.w + 1);
            end else begin
                mem_ready = 1'b0;
            end
        end
        mem_ready = 1'b0;
        if (!ok) begin
            chk("completion_timeout", 0, 1);
            sb_q.delete();
            need_reset = 1'b1;
        end
        if (trap) need_reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1; opcode = 6'h00; funct = 6'h00; branch = 1'b0; mem_ready = 1'b0;

        //            op     fn     br w   cyc cause rf wrsel  wdsel  dm dmwr   dmsel  npc    ca alu     b  e
        vt[0]  = mk(6'h00, 6'h20, 0, 0,  4, 2'b00, 1, 2'b01, 2'b00, 0, 2'b00, 2'b00, 2'b00, 1, 3'b000, 0, 0); // add
        vt[1]  = mk(6'h00, 6'h22, 0, 0,  4, 2'b00, 1, 2'b01, 2'b00, 0, 2'b00, 2'b00, 2'b00, 1, 3'b001, 0, 0); // sub
        vt[2]  = mk(6'h0d, 6'h00, 0, 0,  4, 2'b00, 1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 1, 3'b010, 1, 0); // ori
        vt[3]  = mk(6'h0f, 6'h00, 0, 0,  4, 2'b00, 1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 1, 3'b011, 1, 0); // lui
        vt[4]  = mk(6'h00, 6'h08, 0, 0,  2, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b11, 0, 3'b000, 0, 0); // jr
        vt[5]  = mk(6'h02, 6'h00, 0, 0,  2, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b10, 0, 3'b000, 0, 0); // j
        vt[6]  = mk(6'h03, 6'h00, 0, 0,  2, 2'b00, 1, 2'b11, 2'b10, 0, 2'b00, 2'b00, 2'b10, 0, 3'b000, 0, 0); // jal
        vt[7]  = mk(6'h04, 6'h00, 0, 0,  3, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b01, 0, 3'b000, 0, 1); // beq nt
        vt[8]  = mk(6'h04, 6'h00, 1, 0,  3, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b01, 0, 3'b000, 0, 1); // beq t
        vt[9]  = mk(6'h01, 6'h00, 1, 0,  3, 2'b00, 1, 2'b11, 2'b10, 0, 2'b00, 2'b00, 2'b01, 0, 3'b000, 0, 0); // bltzal t
        vt[10] = mk(6'h01, 6'h00, 0, 0,  3, 2'b00, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b01, 0, 3'b000, 0, 0); // bltzal nt
        vt[11] = mk(6'h23, 6'h00, 0, 0,  5, 2'b00, 1, 2'b00, 2'b01, 1, 2'b01, 2'b00, 2'b00, 1, 3'b000, 1, 1); // lw
        vt[12] = mk(6'h23, 6'h00, 0, 3,  8, 2'b00, 1, 2'b00, 2'b01, 4, 2'b01, 2'b00, 2'b00, 1, 3'b000, 1, 1); // lw w3
        vt[13] = mk(6'h2b, 6'h00, 0, 2,  6, 2'b00, 0, 2'b00, 2'b00, 3, 2'b10, 2'b00, 2'b00, 1, 3'b000, 1, 1); // sw w2
        vt[14] = mk(6'h21, 6'h00, 0, 1,  6, 2'b00, 1, 2'b00, 2'b01, 2, 2'b01, 2'b01, 2'b00, 1, 3'b000, 1, 1); // lh w1
        vt[15] = mk(6'h20, 6'h00, 0, 0,  5, 2'b00, 1, 2'b00, 2'b01, 1, 2'b01, 2'b10, 2'b00, 1, 3'b000, 1, 1); // lb
        vt[16] = mk(6'h29, 6'h00, 0, 0,  4, 2'b00, 0, 2'b00, 2'b00, 1, 2'b10, 2'b01, 2'b00, 1, 3'b000, 1, 1); // sh
        vt[17] = mk(6'h28, 6'h00, 0, 5,  9, 2'b00, 0, 2'b00, 2'b00, 6, 2'b10, 2'b10, 2'b00, 1, 3'b000, 1, 1); // sb w5
        vt[18] = mk(6'h2b, 6'h00, 0, 15, 19, 2'b00, 0, 2'b00, 2'b00, 16, 2'b10, 2'b00, 2'b00, 1, 3'b000, 1, 1); // sw ready last
        vt[19] = mk(6'h2b, 6'h00, 0, 99, 20, 2'b10, 0, 2'b00, 2'b00, 16, 2'b10, 2'b00, 2'b00, 0, 3'b000, 0, 0); // sw timeout
        vt[20] = mk(6'h3f, 6'h00, 0, 0,  3, 2'b01, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 0, 0); // illegal op
        vt[21] = mk(6'h00, 6'h3f, 0, 0,  3, 2'b01, 0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 3'b000, 0, 0); // bad funct

        for (int i = 0; i < 22; i++) begin
            run_vec(vt[i]);
            if (vt[i].cause != 2'b00) begin
                repeat (3) begin
                    @(negedge clk); #1;
                    chk("trap_held", int'({trap, trap_cause, PCWr, RFWr, DMWr}),
                        int'({1'b1, vt[i].cause, 4'b0000}));
                end
            end
        end

        // Reduced-ISA instance: lb and bltzal trap right after DECODE
        need_reset = 1'b1;
        run_vec(vt[15]);
        chk("d2_lb_trap_cycle", d2_trap_cyc, 3);
        chk("d2_lb_cause", int'({d2_trap, d2_cause}), int'({1'b1, 2'b01}));
        need_reset = 1'b1;
        run_vec(vt[9]);
        chk("d2_bltzal_trap_cycle", d2_trap_cyc, 3);
        chk("d2_bltzal_cause", int'({d2_trap, d2_cause}), int'({1'b1, 2'b01}));

        // Reset in the middle of a load's MEM wait aborts it cleanly
        begin
            int mem_seen;
            need_reset = 1'b1;
            opcode = 6'h23; funct = 6'h00; branch = 1'b0; mem_ready = 1'b0;
            do_reset();
            need_reset = 1'b0;
            mem_seen = 0;
            for (int k = 0; k < 20 && mem_seen < 3; k++) begin
                @(posedge clk); #1;
                if (DMWr == 2'b01) mem_seen++;
            end
            chk("abort_mem_reached", mem_seen, 3);
            reset = 1'b1;
            #1 chk("abort_enables", int'({PCWr, IRWr, RFWr, retire, DMWr}), 0);
            need_reset = 1'b1;
            run_vec(vt[0]);
        end

        chk("scoreboard_empty", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (compared %0d)", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
